fp_add_align: RTL and testbench
===============================

Name: fp_add_align

Overview:
- Pipelined front end of the FP adder; sits directly upstream of the normalizer.
- Takes two packed IEEE-style operands, orders them by magnitude, and aligns the smaller mantissa to the larger exponent.
- Performs a signed-magnitude add/subtract and emits sign, unnormalized magnitude and exponent in exactly the format the normalizer consumes.
- Two register stages with a valid/ready handshake, so FC accumulation loops can stall it.

Parameters:
- EXPONENT, 8, exponent field width
- MANTISSA, 23, stored mantissa field width (hidden bit excluded)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operand pair this cycle
- a_i  input  EXPONENT+MANTISSA+1  operand A {sign, exp, man}
- b_i  input  EXPONENT+MANTISSA+1  operand B {sign, exp, man}
- out_valid  output  1  result valid
- out_ready  input  1  downstream consumes result this cycle
- sum_sign  output  1  result sign
- sum_unsigned  output  MANTISSA+5  result magnitude, unnormalized
- sum_exp  output  EXPONENT  exponent of larger operand

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, sum_sign=0, sum_unsigned=0, sum_exp=0.
  - Internal stage valids=0. Both stages flush immediately on reset, including mid-operation; in_ready=1 once rst deasserts.
- Operand decode:
  - exp==0 means zero: the operand's magnitude is taken as 0 and no hidden bit is added.
  - Otherwise the extended mantissa is {1'b1, man}.
  - exp all-ones is treated as an ordinary finite exponent; no NaN/Inf handling.
- Magnitude format (MANTISSA+5 bits):
  - Bits [M+4:M+3] are carry headroom, bit [M+2] is the hidden-bit position, bits [M+1:2] hold the mantissa, and bits [1:0] are guard bits.
  - An aligned operand is {2'b00, hidden, man, 2'b00} >> shift.
- Stage 1 (registered):
  - Compare {exp,man} of A and B; the larger becomes L and the other S. On a tie, L=A.
  - Register L and S fields, diff = expL - expS (EXPONENT bits, unsigned), and op_sub = signA ^ signB.
- Stage 2 (registered):
  - Shift S right by diff. If diff >= MANTISSA+3, S contributes 0.
  - mag = op_sub ? L - S : L + S. The result is never negative because of the stage-1 ordering.
  - sum_exp = expL, sum_sign = signL.
  - Exact cancellation (mag==0) forces sum_sign=0.
  - Both operands zero gives sum_sign = signA & signB, sum_exp=0, sum_unsigned=0.
- Handshake and pipeline:
  - A transfer occurs when in_valid & in_ready.
  - Stage 2 loads when it is empty or out_ready=1. Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = ~s1_valid | s2_load, with no combinational path from in_valid.
  - Latency is 2 cycles from input transfer to out_valid. Throughput is 1 per cycle with out_ready=1.
  - When out_valid=1 and out_ready=0, all outputs hold stable. Up to 2 pairs are buffered; no loss and no duplication.
  - A simultaneous output consume and input accept in the same cycle is legal when full.

Optional Feature:
- Macro: FP_ADD_STICKY_EN.
- Defined: any 1 bit shifted out of S, including the whole operand when diff >= MANTISSA+3 and S is nonzero, is ORed into sum bit 0 before the add/sub.
- Undefined: shifted-out bits are truncated.

Test Plan (EXPONENT=8, MANTISSA=23):
- 1.0 + 1.0:
  - Stimulus: a=0x3F800000, b=0x3F800000, out_ready=1.
  - Response: 2 cycles later out_valid=1, sum_sign=0, sum_exp=0x7F, sum_unsigned=0x4000000.
- Exact cancellation, 1.0 + (-1.0):
  - Stimulus: a=0x3F800000, b=0xBF800000.
  - Response: sum_sign=0, sum_exp=0x7F, sum_unsigned=0.
- Zero operand plus -3.0:
  - Stimulus: a=0x00000000, b=0xC0400000.
  - Response: sum_sign=1, sum_exp=0x80, sum_unsigned=0x3000000.
- Large exponent gap, 1.0 + 2^-30:
  - Stimulus: a=0x3F800000, b=0x30800000.
  - Response: sum_unsigned=0x2000000 without the macro; 0x2000001 with FP_ADD_STICKY_EN.
- Backpressure:
  - Stimulus: out_ready=0 while 4 back-to-back pairs are offered.
  - Response: in_ready drops after 2 accepted and outputs hold stable. Releasing out_ready delivers all pairs in order with no loss and no duplicates.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously with both stages full.
  - Response: out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale results appear.

Source files
------------

// File: rtl/fp_add_align_if.sv
// Operand-pair / result handshake bundle between the FP adder front end and its neighbours.
interface fp_add_align_if #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23
);
  logic                         in_valid;
  logic                         in_ready;
  logic [EXPONENT+MANTISSA:0]   a_i;
  logic [EXPONENT+MANTISSA:0]   b_i;
  logic                         out_valid;
  logic                         out_ready;
  logic                         sum_sign;
  logic [MANTISSA+4:0]          sum_unsigned;
  logic [EXPONENT-1:0]          sum_exp;

  modport master (
    output in_valid, a_i, b_i, out_ready,
    input  in_ready, out_valid, sum_sign, sum_unsigned, sum_exp
  );

  modport slave (
    input  in_valid, a_i, b_i, out_ready,
    output in_ready, out_valid, sum_sign, sum_unsigned, sum_exp
  );
endinterface

// File: rtl/fp_add_align.sv
// FP adder front end: magnitude sort, align, signed-magnitude add; 2-cycle latency, 1/cycle, stalls on out_ready=0.
// FP_ADD_STICKY_EN: OR bits shifted out of the smaller operand into bit 0; undefined truncates them.
module fp_add_align #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23
) (
  input logic          clk,
  input logic          rst,
  fp_add_align_if.slave io
);
  localparam int          MW        = MANTISSA + 5;
  localparam logic [31:0] FAR_SHIFT = 32'(MANTISSA + 3);

  typedef struct packed {
    logic                sign_l;
    logic [EXPONENT-1:0] exp_l;
    logic [MANTISSA:0]   mant_l;
    logic [MANTISSA:0]   mant_s;
    logic [EXPONENT-1:0] diff;
    logic                op_sub;
    logic                both_zero;
    logic                zero_sign;
  } s1_t;

  logic                s1_valid;
  logic                s1_load;
  logic                s2_load;
  s1_t                 s1_d;
  s1_t                 s1_q;

  logic                sign_a;
  logic                sign_b;
  logic [EXPONENT-1:0] exp_a;
  logic [EXPONENT-1:0] exp_b;
  logic [MANTISSA-1:0] man_a;
  logic [MANTISSA-1:0] man_b;
  logic [MANTISSA:0]   ext_a;
  logic [MANTISSA:0]   ext_b;
  logic                a_larger;

  logic [MW-1:0]       l_al;
  logic [MW-1:0]       s_full;
  logic [MW-1:0]       s_sh;
  logic [MW-1:0]       mag;
  logic [31:0]         diff32;
  logic                far;
  logic                sign_d;
`ifdef FP_ADD_STICKY_EN
  logic                sticky;
`endif

  logic                out_valid_q;
  logic                sum_sign_q;
  logic [MW-1:0]       sum_unsigned_q;
  logic [EXPONENT-1:0] sum_exp_q;

  assign {sign_a, exp_a, man_a} = io.a_i;
  assign {sign_b, exp_b, man_b} = io.b_i;

  // A zero exponent means a zero operand: no hidden bit and no mantissa contribution.
  assign ext_a = (exp_a == '0) ? '0 : {1'b1, man_a};
  assign ext_b = (exp_b == '0) ? '0 : {1'b1, man_b};

  always_comb begin
    a_larger       = {exp_a, man_a} >= {exp_b, man_b};
    s1_d           = '0;
    s1_d.sign_l    = a_larger ? sign_a : sign_b;
    s1_d.exp_l     = a_larger ? exp_a  : exp_b;
    s1_d.mant_l    = a_larger ? ext_a  : ext_b;
    s1_d.mant_s    = a_larger ? ext_b  : ext_a;
    s1_d.diff      = a_larger ? (exp_a - exp_b) : (exp_b - exp_a);
    s1_d.op_sub    = sign_a ^ sign_b;
    s1_d.both_zero = (exp_a == '0) && (exp_b == '0);
    s1_d.zero_sign = sign_a & sign_b;
  end

  always_comb begin
    l_al   = {2'b00, s1_q.mant_l, 2'b00};
    s_full = {2'b00, s1_q.mant_s, 2'b00};
    diff32 = 32'(s1_q.diff);
    far    = diff32 >= FAR_SHIFT;
    s_sh   = far ? '0 : (s_full >> s1_q.diff);
`ifdef FP_ADD_STICKY_EN
    // Shifting back and comparing detects any lost 1 without building a mask.
    sticky  = far ? (|s_full) : ((s_sh << s1_q.diff) != s_full);
    s_sh[0] = s_sh[0] | sticky;
`endif
    mag    = s1_q.op_sub ? (l_al - s_sh) : (l_al + s_sh);
    if (s1_q.both_zero) begin
      sign_d = s1_q.zero_sign;
    end else if (mag == '0) begin
      sign_d = 1'b0;
    end else begin
      sign_d = s1_q.sign_l;
    end
  end

  assign s2_load     = ~out_valid_q | io.out_ready;
  assign s1_load     = ~s1_valid | s2_load;
  assign io.in_ready = s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      sum_sign_q     <= 1'b0;
      sum_unsigned_q <= '0;
      sum_exp_q      <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum_sign_q     <= sign_d;
        sum_unsigned_q <= mag;
        sum_exp_q      <= s1_q.exp_l;
      end
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.sum_sign     = sum_sign_q;
  assign io.sum_unsigned = sum_unsigned_q;
  assign io.sum_exp      = sum_exp_q;
endmodule

// File: tb/tb_fp_add_align.sv
// Bench for fp_add_align: directed vector table, random stream against a reference model, stall and reset sequences.
module tb_fp_add_align;
  localparam int E = 8;
  localparam int M = 23;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mag;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   npass  = 0;
  int   ntotal = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_add_align_if #(.EXPONENT(E), .MANTISSA(M)) bus ();

  fp_add_align #(.EXPONENT(E), .MANTISSA(M)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    ntotal++;
    if (act == req) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: real-valued magnitudes scaled by 4 (two guard bits), aligned by integer division.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l;
    logic [31:0] s;
    longint      ml, ms, al, full, sh, mag;
    int          d;
    bit          sticky;
    res_t        r;
    if (a[30:0] >= b[30:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    ml     = (l[30:23] == 8'd0) ? 64'd0 : longint'({1'b1, l[22:0]});
    ms     = (s[30:23] == 8'd0) ? 64'd0 : longint'({1'b1, s[22:0]});
    d      = int'(l[30:23]) - int'(s[30:23]);
    al     = ml * 4;
    full   = ms * 4;
    if (d >= 26) begin
      sh     = 0;
      sticky = (full != 0);
    end else begin
      sh     = full / (longint'(1) << d);
      sticky = (full % (longint'(1) << d)) != 0;
    end
`ifdef FP_ADD_STICKY_EN
    if (sticky) sh = sh | 64'd1;
`endif
    mag   = (a[31] ^ b[31]) ? (al - sh) : (al + sh);
    r.mag = mag[27:0];
    r.exp = l[30:23];
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) r.sign = a[31] & b[31];
    else if (mag == 0)                        r.sign = 1'b0;
    else                                      r.sign = l[31];
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic step(output bit acc);
    res_t e;
    acc = 1'b0;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a_i, bus.b_i));
      acc = 1'b1;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_sign", 64'(bus.sum_sign), 64'(e.sign));
        check("sb_exp", 64'(bus.sum_exp), 64'(e.exp));
        check("sb_mag", 64'(bus.sum_unsigned), 64'(e.mag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tv[6];
    logic [31:0] bp_a[4];
    logic [31:0] ra, rb;
    logic [36:0] snap;
    int          mode, k, guard;
    bit          acc;

    tv[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 28'h4000000};
    tv[1] = '{32'h3F800000, 32'hBF800000, 1'b0, 8'h7F, 28'h0000000};
    tv[2] = '{32'h00000000, 32'hC0400000, 1'b1, 8'h80, 28'h3000000};
`ifdef FP_ADD_STICKY_EN
    tv[3] = '{32'h3F800000, 32'h30800000, 1'b0, 8'h7F, 28'h2000001};
`else
    tv[3] = '{32'h3F800000, 32'h30800000, 1'b0, 8'h7F, 28'h2000000};
`endif
    tv[4] = '{32'h40000000, 32'hBF800000, 1'b0, 8'h80, 28'h1000000};
    tv[5] = '{32'h80000000, 32'h80000000, 1'b1, 8'h00, 28'h0000000};
    bp_a  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    rst           = 1'b0;
    #1 rst = 1'b1;
    #10;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_sum_sign", 64'(bus.sum_sign), 0);
    check("rst_sum_exp", 64'(bus.sum_exp), 0);
    check("rst_sum_unsigned", 64'(bus.sum_unsigned), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 1);

    // Directed vectors, one pair at a time, with latency observed cycle by cycle.
    for (int i = 0; i < 6; i++) begin
      bus.a_i       = tv[i].a;
      bus.b_i       = tv[i].b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check($sformatf("tbl%0d_lat1_valid", i), 64'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_lat2_valid", i), 64'(bus.out_valid), 1);
      check($sformatf("tbl%0d_sign", i), 64'(bus.sum_sign), 64'(tv[i].sign));
      check($sformatf("tbl%0d_exp", i), 64'(bus.sum_exp), 64'(tv[i].exp));
      check($sformatf("tbl%0d_mag", i), 64'(bus.sum_unsigned), 64'(tv[i].mag));
      @(posedge clk);
      #1;
    end

    // Random stream with random stalls, scored against the model.
    for (int c = 0; c < 400; c++) begin
      ra   = $urandom;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: rb = $urandom;
        1: begin
          rb        = $urandom;
          rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
        end
        2: rb = ra ^ {1'($urandom_range(0, 1)), 31'h0};
        default: begin
          rb        = $urandom;
          ra[30:23] = 8'd0;
          if ($urandom_range(0, 1) == 1) rb[30:23] = 8'd0;
        end
      endcase
      bus.a_i       = ra;
      bus.b_i       = rb;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      step(acc);
      guard++;
    end
    check("rand_drained", 64'(exp_q.size()), 0);

    // Backpressure: four pairs offered against a stalled output.
    bus.b_i       = 32'h3F800000;
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.a_i      = bp_a[k];
      step(acc);
      if (acc) k++;
    end
    check("bp_accepted", 64'(k), 2);
    check("bp_in_ready_low", 64'(bus.in_ready), 0);
    check("bp_out_valid", 64'(bus.out_valid), 1);
    snap = {bus.sum_sign, bus.sum_exp, bus.sum_unsigned};
    for (int c = 0; c < 3; c++) begin
      step(acc);
      check("bp_hold", 64'({bus.sum_sign, bus.sum_exp, bus.sum_unsigned}), 64'(snap));
    end
    bus.out_ready = 1'b1;
    guard = 0;
    while (k < 4 && guard < 20) begin
      bus.in_valid = 1'b1;
      bus.a_i      = bp_a[k];
      step(acc);
      if (acc) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      step(acc);
      guard++;
    end
    check("bp_all_sent", 64'(k), 4);
    check("bp_drained", 64'(exp_q.size()), 0);

    // Reset with both stages full, asserted between clock edges.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_i       = 32'h40400000;
    step(acc);
    step(acc);
    bus.in_valid = 1'b0;
    check("mid_full_out_valid", 64'(bus.out_valid), 1);
    check("mid_full_in_ready", 64'(bus.in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 0);
    check("mid_rst_outputs", 64'({bus.sum_sign, bus.sum_exp, bus.sum_unsigned}), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 64'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(acc);
      check("mid_no_stale", 64'(bus.out_valid), 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
